serial_sub16: RTL and testbench
===============================

# serial_sub16

Digit-serial 16-bit subtractor computing `diff = a - b - b_in` one 4-bit digit per clock, LSB digit first, with a start/busy/done handshake. It is the inverse-arithmetic companion to the team's 16-bit carry-select adder and sits beside it in the arithmetic datapath. It trades latency for a single small digit subtractor instead of a full-width borrow chain.

## Interface
Parameters:
- `WIDTH`, 16: operand and result width; must be an integer multiple of `DIGIT`.
- `DIGIT`, 4: bits processed per cycle.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: request; sampled only while idle.
- `a`  in  WIDTH: minuend; sampled with an accepted `start`.
- `b`  in  WIDTH: subtrahend; sampled with an accepted `start`.
- `b_in`  in  1: borrow in; sampled with an accepted `start`.
- `busy`  out  1: high from the accepting edge until return to IDLE.
- `done`  out  1: one-cycle pulse; `diff` and `b_out` are valid.
- `diff`  out  WIDTH: result; held stable until the next accepted `start`.
- `b_out`  out  1: borrow out of the MSB; 1 when `a < b + b_in` (unsigned).

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE with `start`=1: latch `a`, `b` and `b_in`, clear the digit counter and `diff`, then go to RUN.
  - IDLE with `start`=0: stay in IDLE.
  - RUN: each cycle subtracts digit `k` as `a[k] - b[k] - borrow`, writes `diff[k]` and updates the borrow register. After digit `WIDTH/DIGIT-1`, go to DONE.
  - DONE: `done`=1 for this one cycle; `b_out` = final borrow; go to IDLE.
- Borrow register starts at the latched `b_in`. The counter is `$clog2(WIDTH/DIGIT)` bits wide and does not wrap during RUN.
- Arithmetic is modulo 2^WIDTH. `diff` equals `(a - b - b_in) mod 2^WIDTH`.
- `start` in RUN or DONE is ignored. It is not queued.
- New operand values on `a`/`b` during RUN have no effect; the latched copies are used.
- Reset values: `busy`=0, `done`=0, `diff`=0, `b_out`=0, state IDLE, counter 0.
- `rst` during RUN or DONE aborts the operation:
  - the next state is IDLE with all outputs at their reset values;
  - no `done` pulse is issued;
  - `rst` has priority over `start` on the same edge.

## Timing
- Accepting edge E0: `busy` rises after E0.
- Digits are processed on E1..E(WIDTH/DIGIT). At the defaults this is E1..E4.
- `done` is high in the cycle after E(WIDTH/DIGIT), so latency is start sample to `done` = WIDTH/DIGIT + 1 cycles (5 at the defaults).
- `busy` falls after E(WIDTH/DIGIT+1). The earliest next accept is that same edge plus one, giving a throughput of 1 operation per WIDTH/DIGIT+2 cycles.
- `diff` is partially updated during RUN. Consumers must use it only when `done`=1 or afterwards.

## Configuration
- Macro `SERIAL_SUB_OVF_EN`.
- Defined: adds output port `ovf` (1 bit), the two's-complement signed overflow.
  - Computed in DONE as `(a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])` on the latched operands.
  - Valid and held on the same terms as `b_out`.
  - Reset value 0.
- Undefined: no `ovf` port and no associated logic. All other behaviour is identical.

## Structure
- Package `serial_sub_pkg` holds:
  - the FSM state typedef (IDLE/RUN/DONE);
  - default `WIDTH`/`DIGIT` constants;
  - a `DIGITS = WIDTH/DIGIT` constant.
- Sub-module `sub_digit`: a combinational DIGIT-bit ripple-borrow subtractor (inputs x, y, bi; outputs d, bo). The top instantiates it once and muxes digit `k` into it.

## Test plan
- Reset, then `a`=0x0000, `b`=0x0000, `b_in`=0, `start` pulse -> `done` 5 cycles after the accept edge, `diff`=0x0000, `b_out`=0.
- `a`=0x0000, `b`=0x0001, `b_in`=0 -> `diff`=0xFFFF, `b_out`=1 (borrow ripples through all four digits).
- `a`=0xFFFF, `b`=0xFFFF, `b_in`=1 -> `diff`=0xFFFF, `b_out`=1. Then `a`=0x1234, `b`=0x0234, `b_in`=0 -> `diff`=0x1000, `b_out`=0.
- With `SERIAL_SUB_OVF_EN`: `a`=0x8000, `b`=0x0001 -> `diff`=0x7FFF, `b_out`=0, `ovf`=1. Then `a`=0x7FFF, `b`=0xFFFF -> `diff`=0x8000, `ovf`=1.
- `start` held high through the whole operation, with `a`/`b` changed mid-RUN -> exactly one `done` per accept, result computed from the originally latched operands, and no accept while `busy`=1.
- `rst` asserted on E2 of an operation -> `busy`=0, `diff`=0, `b_out`=0 after that edge, and no `done` pulse. A fresh `start` afterwards completes normally.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM state encoding
// and default geometry. Optional signed-overflow output is enabled by
// defining SERIAL_SUB_OVF_EN when building serial_sub16.
package serial_sub_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  localparam int unsigned SUB_WIDTH = 16;
  localparam int unsigned SUB_DIGIT = 4;
  localparam int unsigned DIGITS    = SUB_WIDTH / SUB_DIGIT;

endpackage

// File: rtl/serial_sub16_sub_digit.sv
// Combinational W-bit ripple-borrow subtractor: d = x - y - bi, bo = borrow out.
module sub_digit #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         bi,
  output logic [W-1:0] d,
  output logic         bo
);

  logic br;

  // Bit-by-bit borrow ripple from LSB to MSB
  always_comb begin
    br = bi;
    d  = '0;
    for (int unsigned i = 0; i < W; i++) begin
      d[i] = x[i] ^ y[i] ^ br;
      br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
    end
    bo = br;
  end

endmodule

// File: rtl/serial_sub16.sv
// Digit-serial subtractor: diff = a - b - b_in, one DIGIT-bit digit per clock,
// LSB digit first, start/busy/done handshake.
// Build option: define SERIAL_SUB_OVF_EN to add the signed-overflow port ovf.
module serial_sub16
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH,
  parameter int unsigned DIGIT = SUB_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] x;
  logic [DIGIT-1:0] y;
  logic [DIGIT-1:0] d;
  logic             bo;
  int unsigned      base;

  // Select the current digit of the latched operands
  always_comb begin
    base = 32'(cnt) * DIGIT;
    x    = a_r[base +: DIGIT];
    y    = b_r[base +: DIGIT];
  end

  sub_digit #(.W(DIGIT)) u_digit (
    .x  (x),
    .y  (y),
    .bi (brw),
    .d  (d),
    .bo (bo)
  );

  // Handshake outputs decoded from the FSM state
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // FSM, operand latches, digit counter, borrow chain and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      b_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            brw   <= b_in;
            cnt   <= '0;
            diff  <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          diff[base +: DIGIT] <= d;
          brw <= bo;
          if (cnt == LAST) begin
            // Final digit: publish borrow (and overflow) so they are valid with done
            b_out <= bo;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (d[DIGIT-1] != a_r[WIDTH-1]);
`endif
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub16.sv
// Self-checking bench for serial_sub16 using directed vectors.
// Define SERIAL_SUB_OVF_EN for both RTL and bench to exercise the ovf port.
module tb_serial_sub16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        b_in;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        b_out;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  serial_sub16 #(.WIDTH(16), .DIGIT(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .b_out (b_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  // Issue one operation and wait (bounded) for done; lat counts cycles from
  // the accepting edge to the cycle in which done is seen.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic tbin, output int lat);
    @(negedge clk);
    a = ta; b = tb_v; b_in = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL reset_diff: got %h expected 0000", diff); end
    checks++; if (b_out !== 1'b0) begin errors++; $display("FAIL reset_bout: got %b expected 0", b_out); end
    rst = 1'b0;
  endtask

  task automatic test_subtract();
    logic [15:0] va [4] = '{16'h0000, 16'h0000, 16'hFFFF, 16'h1234};
    logic [15:0] vb [4] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0234};
    logic        vi [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] ed [4] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h1000};
    logic        eb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], vi[i], lat);
      checks++; if (lat !== 5) begin errors++; $display("FAIL vec%0d_latency: got %0d expected 5", i, lat); end
      checks++; if (diff !== ed[i]) begin errors++; $display("FAIL vec%0d_diff: got %h expected %h", i, diff, ed[i]); end
      checks++; if (b_out !== eb[i]) begin errors++; $display("FAIL vec%0d_bout: got %b expected %b", i, b_out, eb[i]); end
      if (i == 0) begin
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done: got %b expected 0", busy); end
      end
    end
    // Result held after completion
    repeat (3) @(negedge clk);
    checks++; if (diff !== 16'h1000) begin errors++; $display("FAIL diff_hold: got %h expected 1000", diff); end
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    int lat;
    do_op(16'h8000, 16'h0001, 1'b0, lat);
    checks++; if (diff !== 16'h7FFF) begin errors++; $display("FAIL ovf1_diff: got %h expected 7fff", diff); end
    checks++; if (b_out !== 1'b0) begin errors++; $display("FAIL ovf1_bout: got %b expected 0", b_out); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf1_ovf: got %b expected 1", ovf); end
    do_op(16'h7FFF, 16'hFFFF, 1'b0, lat);
    checks++; if (diff !== 16'h8000) begin errors++; $display("FAIL ovf2_diff: got %h expected 8000", diff); end
    checks++; if (b_out !== 1'b1) begin errors++; $display("FAIL ovf2_bout: got %b expected 1", b_out); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf2_ovf: got %b expected 1", ovf); end
    do_op(16'h1234, 16'h0234, 1'b0, lat);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf3_ovf: got %b expected 0", ovf); end
  endtask
`endif

  task automatic test_start_held();
    int n;
    int busy_gaps;
    int dones;
    @(negedge clk);
    a = 16'h5555; b = 16'h1111; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    // Operands change mid-RUN while start stays high
    a = 16'hFFFF; b = 16'h0000; b_in = 1'b1;
    n = 1; busy_gaps = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (!busy) busy_gaps++;
    end
    checks++; if (n !== 5) begin errors++; $display("FAIL held_latency: got %0d expected 5", n); end
    checks++; if (busy_gaps !== 0) begin errors++; $display("FAIL held_busy_gap: got %0d expected 0", busy_gaps); end
    checks++; if (diff !== 16'h4444) begin errors++; $display("FAIL held_diff: got %h expected 4444", diff); end
    checks++; if (b_out !== 1'b0) begin errors++; $display("FAIL held_bout: got %b expected 0", b_out); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_no_accept_in_done: got busy %b expected 0", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL held_reaccept: got busy %b expected 1", busy); end
    start = 1'b0;
    n = 1; dones = 0;
    while (n < 12) begin
      @(negedge clk);
      n++;
      if (done) begin
        dones++;
        checks++; if (diff !== 16'hFFFE) begin errors++; $display("FAIL held_second_diff: got %h expected fffe", diff); end
      end
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL held_second_done_count: got %0d expected 1", dones); end
  endtask

  task automatic test_reset_abort();
    int lat;
    int dones;
    do_op(16'h0000, 16'h0001, 1'b0, lat);
    @(negedge clk);
    a = 16'h0005; b = 16'h0001; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_run: got %b expected 1", busy); end
    checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL abort_diff_cleared: got %h expected 0000", diff); end
    checks++; if (b_out !== 1'b1) begin errors++; $display("FAIL abort_bout_held: got %b expected 1", b_out); end
    @(negedge clk);
    checks++; if (diff !== 16'h0004) begin errors++; $display("FAIL abort_digit0: got %h expected 0004", diff); end
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL abort_diff: got %h expected 0000", diff); end
    checks++; if (b_out !== 1'b0) begin errors++; $display("FAIL abort_bout: got %b expected 0", b_out); end
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", dones); end
    do_op(16'h0010, 16'h0001, 1'b0, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL after_abort_latency: got %0d expected 5", lat); end
    checks++; if (diff !== 16'h000F) begin errors++; $display("FAIL after_abort_diff: got %h expected 000f", diff); end
    checks++; if (b_out !== 1'b0) begin errors++; $display("FAIL after_abort_bout: got %b expected 0", b_out); end
  endtask

  initial begin
    test_reset();
    test_subtract();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_start_held();
    test_reset_abort();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
